// File: rtl/multi_phase_traffic_controller.sv
// Multi-phase traffic signal controller.
// One phase at a time holds right-of-way and cycles GREEN -> YELLOW -> ALL_RED.
// Requests are latched per phase and served round-robin. The controller rests
// in green while no other phase is waiting.
module multi_phase_traffic_controller #(
    parameter int NUM_PHASES   = 4,
    parameter int MIN_GREEN    = 20,
    parameter int MAX_GREEN    = 50,
    parameter int YELLOW_TIME  = 10,
    parameter int ALL_RED_TIME = 3,
    parameter int TIMER_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PHASES-1:0]         sensor,
    output logic [3*NUM_PHASES-1:0]       lights,
    output logic [$clog2(NUM_PHASES)-1:0] active_phase,
    output logic [NUM_PHASES-1:0]         req_pending
);
    localparam int PW = $clog2(NUM_PHASES);

    // Last timer value of each interval; a state is left on the edge where
    // the timer has reached this value.
    localparam logic [TIMER_W-1:0] MIN_LAST = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] MAX_LAST = TIMER_W'(MAX_GREEN - 1);
    localparam logic [TIMER_W-1:0] YEL_LAST = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] AR_LAST  = TIMER_W'(ALL_RED_TIME - 1);

    typedef enum logic [1:0] {
        GREEN   = 2'b00,
        YELLOW  = 2'b01,
        ALL_RED = 2'b10
    } state_t;

    state_t                state, state_n;
    logic [PW-1:0]         active_n;
    logic [PW-1:0]         next_phase, next_phase_n;
    logic [TIMER_W-1:0]    timer, timer_n;
    logic [NUM_PHASES-1:0] req_n, req_set, clear_mask;
    logic [NUM_PHASES-1:0] active_onehot, next_onehot;
    logic                  phase_ok, others_pending, sensor_active;
    logic                  found_hi, found_lo, recover;
    logic [PW-1:0]         hi_phase, lo_phase, rr_phase;

    // Decode the current and queued phase, and pick the round-robin successor:
    // the lowest pending phase above active_phase, else the lowest one below it.
    always_comb begin
        phase_ok      = 1'b0;
        active_onehot = '0;
        next_onehot   = '0;
        found_hi      = 1'b0;
        found_lo      = 1'b0;
        hi_phase      = '0;
        lo_phase      = '0;
        for (int unsigned i = 0; i < NUM_PHASES; i++) begin
            if (active_phase == PW'(i)) begin
                phase_ok         = 1'b1;
                active_onehot[i] = 1'b1;
            end
            if (next_phase == PW'(i)) begin
                next_onehot[i] = 1'b1;
            end
            if (req_pending[i] && (PW'(i) > active_phase) && !found_hi) begin
                found_hi = 1'b1;
                hi_phase = PW'(i);
            end
            if (req_pending[i] && (PW'(i) < active_phase) && !found_lo) begin
                found_lo = 1'b1;
                lo_phase = PW'(i);
            end
        end
        rr_phase       = found_hi ? hi_phase : lo_phase;
        others_pending = |(req_pending & ~active_onehot);
        sensor_active  = |(sensor & active_onehot);
    end

    // Next-state, request latch and interval timer.
    always_comb begin
        state_n      = state;
        active_n     = active_phase;
        next_phase_n = next_phase;
        clear_mask   = '0;
        recover      = 1'b0;
        req_set      = sensor;
        if (state == GREEN) begin
            req_set = sensor & ~active_onehot;
        end
        if (!phase_ok) begin
            recover = 1'b1;
        end else begin
            case (state)
                GREEN: begin
                    if ((timer >= MIN_LAST) && others_pending &&
                        (!sensor_active || (timer >= MAX_LAST))) begin
                        state_n      = YELLOW;
                        next_phase_n = rr_phase;
                    end
                end
                YELLOW: begin
                    if (timer >= YEL_LAST) begin
                        state_n = ALL_RED;
                    end
                end
                ALL_RED: begin
                    if (timer >= AR_LAST) begin
                        state_n    = GREEN;
                        active_n   = next_phase;
                        clear_mask = next_onehot;
                    end
                end
                default: recover = 1'b1;
            endcase
        end
        if (recover) begin
            state_n    = GREEN;
            active_n   = '0;
            clear_mask = NUM_PHASES'(1);
        end
        // Clearing on green entry wins over a request arriving on the same edge.
        req_n = (req_pending | req_set) & ~clear_mask;
        if ((state_n != state) || recover) begin
            timer_n = '0;
        end else if (timer == '1) begin
            timer_n = timer;
        end else begin
            timer_n = timer + 1'b1;
        end
    end

    // State, phase, timer and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= GREEN;
            active_phase <= '0;
            next_phase   <= '0;
            timer        <= '0;
            req_pending  <= '0;
        end else begin
            state        <= state_n;
            active_phase <= active_n;
            next_phase   <= next_phase_n;
            timer        <= timer_n;
            req_pending  <= req_n;
        end
    end

    // Lamp decode from registered state only; invalid encodings show all red.
    always_comb begin
        lights = {NUM_PHASES{3'b100}};
        if (phase_ok) begin
            for (int unsigned i = 0; i < NUM_PHASES; i++) begin
                if (active_onehot[i]) begin
                    if (state == GREEN) begin
                        lights[3*i +: 3] = 3'b001;
                    end else if (state == YELLOW) begin
                        lights[3*i +: 3] = 3'b010;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Directed testbench for multi_phase_traffic_controller with a per-cycle
// lamp scoreboard running alongside the scenario tasks.
module tb_multi_phase_traffic_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sensor = '0;
    logic [11:0] lights;
    logic [1:0]  active_phase;
    logic [3:0]  req_pending;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_phase_traffic_controller #(
        .NUM_PHASES(4),
        .MIN_GREEN(4),
        .MAX_GREEN(8),
        .YELLOW_TIME(2),
        .ALL_RED_TIME(1),
        .TIMER_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sensor(sensor),
        .lights(lights),
        .active_phase(active_phase),
        .req_pending(req_pending)
    );

    // kind: 0 = green, 1 = yellow, 2 = all red
    function automatic logic [11:0] lamps(input int ph, input int kind);
        logic [11:0] v;
        v = {4{3'b100}};
        if (kind == 0) v[3*ph +: 3] = 3'b001;
        else if (kind == 1) v[3*ph +: 3] = 3'b010;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at cycle 0 (first cycle after the reset edge).
    task automatic do_reset();
        rst    = 1'b1;
        sensor = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard: at most one non-red lamp, yellow runs of 2, all-red runs of 1.
    int          sb_nonred;
    int          yel_run = 0;
    int          ar_run = 0;
    logic        sb_yel;
    logic [2:0]  sb_lamp;
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                yel_run = 0;
                ar_run  = 0;
            end else begin
                sb_nonred = 0;
                sb_yel    = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    sb_lamp = lights[3*i +: 3];
                    if (sb_lamp !== 3'b100) sb_nonred++;
                    if (sb_lamp === 3'b010) sb_yel = 1'b1;
                end
                n_cmp++;
                if (sb_nonred > 1) begin
                    n_err++;
                    $display("FAIL sb_one_lamp t=%0t nonred=%0d required<=1 lights=%b", $time, sb_nonred, lights);
                end
                if (sb_yel) begin
                    yel_run++;
                end else if (yel_run != 0) begin
                    n_cmp++;
                    if (yel_run != 2) begin
                        n_err++;
                        $display("FAIL sb_yellow_len t=%0t got %0d required 2", $time, yel_run);
                    end
                    yel_run = 0;
                end
                if (sb_nonred == 0) begin
                    ar_run++;
                end else if (ar_run != 0) begin
                    n_cmp++;
                    if (ar_run != 1) begin
                        n_err++;
                        $display("FAIL sb_allred_len t=%0t got %0d required 1", $time, ar_run);
                    end
                    ar_run = 0;
                end
            end
        end
    end

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (lights !== 12'b100_100_100_001) begin
            n_err++;
            $display("FAIL reset_lights got %b required %b", lights, 12'b100_100_100_001);
        end
        n_cmp++;
        if (active_phase !== 2'd0) begin
            n_err++;
            $display("FAIL reset_active got %0d required 0", active_phase);
        end
        n_cmp++;
        if (req_pending !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_pending got %b required 0000", req_pending);
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int c = 0; c < 30; c++) begin
            n_cmp++;
            if (lights !== 12'b100_100_100_001) begin
                n_err++;
                $display("FAIL idle_lights c=%0d got %b required %b", c, lights, 12'b100_100_100_001);
            end
            n_cmp++;
            if (req_pending !== 4'b0000) begin
                n_err++;
                $display("FAIL idle_pending c=%0d got %b required 0000", c, req_pending);
            end
            step();
        end
    endtask

    task automatic test_rest_in_green();
        do_reset();
        sensor = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            n_cmp++;
            if (lights !== lamps(0, 0)) begin
                n_err++;
                $display("FAIL rest_lights c=%0d got %b required %b", c, lights, lamps(0, 0));
            end
            n_cmp++;
            if (req_pending !== 4'b0000) begin
                n_err++;
                $display("FAIL rest_pending c=%0d got %b required 0000", c, req_pending);
            end
            step();
        end
        sensor = '0;
    endtask

    task automatic test_single_request();
        logic [11:0] el;
        logic [1:0]  ea;
        logic [3:0]  ep;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            sensor = (c == 1) ? 4'b0100 : 4'b0000;
            el = (c <= 3) ? lamps(0, 0) : (c <= 5) ? lamps(0, 1) : (c == 6) ? lamps(0, 2) : lamps(2, 0);
            ea = (c <= 6) ? 2'd0 : 2'd2;
            ep = (c >= 2 && c <= 6) ? 4'b0100 : 4'b0000;
            n_cmp++;
            if (lights !== el) begin
                n_err++;
                $display("FAIL single_lights c=%0d got %b required %b", c, lights, el);
            end
            n_cmp++;
            if (active_phase !== ea) begin
                n_err++;
                $display("FAIL single_active c=%0d got %0d required %0d", c, active_phase, ea);
            end
            n_cmp++;
            if (req_pending !== ep) begin
                n_err++;
                $display("FAIL single_pending c=%0d got %b required %b", c, req_pending, ep);
            end
            step();
        end
        sensor = '0;
    endtask

    task automatic test_max_out();
        logic [11:0] el;
        logic [1:0]  ea;
        logic [3:0]  ep;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            sensor = 4'b0001 | ((c == 1) ? 4'b0010 : 4'b0000);
            el = (c <= 7) ? lamps(0, 0) : (c <= 9) ? lamps(0, 1) : (c == 10) ? lamps(0, 2) : lamps(1, 0);
            ea = (c <= 10) ? 2'd0 : 2'd1;
            ep = (c < 2) ? 4'b0000 : (c <= 8) ? 4'b0010 : (c <= 10) ? 4'b0011 : 4'b0001;
            n_cmp++;
            if (lights !== el) begin
                n_err++;
                $display("FAIL maxout_lights c=%0d got %b required %b", c, lights, el);
            end
            n_cmp++;
            if (active_phase !== ea) begin
                n_err++;
                $display("FAIL maxout_active c=%0d got %0d required %0d", c, active_phase, ea);
            end
            n_cmp++;
            if (req_pending !== ep) begin
                n_err++;
                $display("FAIL maxout_pending c=%0d got %b required %b", c, req_pending, ep);
            end
            step();
        end
        sensor = '0;
    endtask

    task automatic test_round_robin();
        logic [11:0] el;
        logic [1:0]  ea;
        logic [3:0]  ep;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            sensor = (c == 1) ? 4'b0100 : (c == 7) ? 4'b1010 : 4'b0000;
            if (c <= 3)       el = lamps(0, 0);
            else if (c <= 5)  el = lamps(0, 1);
            else if (c == 6)  el = lamps(0, 2);
            else if (c <= 10) el = lamps(2, 0);
            else if (c <= 12) el = lamps(2, 1);
            else if (c == 13) el = lamps(2, 2);
            else if (c <= 17) el = lamps(3, 0);
            else if (c <= 19) el = lamps(3, 1);
            else if (c == 20) el = lamps(3, 2);
            else              el = lamps(1, 0);
            ea = (c <= 6) ? 2'd0 : (c <= 13) ? 2'd2 : (c <= 20) ? 2'd3 : 2'd1;
            if (c <= 1)       ep = 4'b0000;
            else if (c <= 6)  ep = 4'b0100;
            else if (c == 7)  ep = 4'b0000;
            else if (c <= 13) ep = 4'b1010;
            else if (c <= 20) ep = 4'b0010;
            else              ep = 4'b0000;
            n_cmp++;
            if (lights !== el) begin
                n_err++;
                $display("FAIL rr_lights c=%0d got %b required %b", c, lights, el);
            end
            n_cmp++;
            if (active_phase !== ea) begin
                n_err++;
                $display("FAIL rr_active c=%0d got %0d required %0d", c, active_phase, ea);
            end
            n_cmp++;
            if (req_pending !== ep) begin
                n_err++;
                $display("FAIL rr_pending c=%0d got %b required %b", c, req_pending, ep);
            end
            step();
        end
        sensor = '0;
    endtask

    task automatic test_reset_mid_yellow();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            sensor = (c == 1) ? 4'b0110 : 4'b0000;
            step();
        end
        // cycle 4: yellow on phase 0 with two requests queued
        n_cmp++;
        if (lights !== lamps(0, 1)) begin
            n_err++;
            $display("FAIL rstyel_pre_lights got %b required %b", lights, lamps(0, 1));
        end
        n_cmp++;
        if (req_pending !== 4'b0110) begin
            n_err++;
            $display("FAIL rstyel_pre_pending got %b required 0110", req_pending);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (lights !== lamps(0, 0)) begin
            n_err++;
            $display("FAIL rstyel_lights got %b required %b", lights, lamps(0, 0));
        end
        n_cmp++;
        if (active_phase !== 2'd0) begin
            n_err++;
            $display("FAIL rstyel_active got %0d required 0", active_phase);
        end
        n_cmp++;
        if (req_pending !== 4'b0000) begin
            n_err++;
            $display("FAIL rstyel_pending got %b required 0000", req_pending);
        end
        // Timer restarted from 0: a fresh request gives exactly 4 green cycles.
        sensor = 4'b1000;
        step();
        sensor = 4'b0000;
        n_cmp++;
        if (req_pending !== 4'b1000) begin
            n_err++;
            $display("FAIL rstyel_newreq got %b required 1000", req_pending);
        end
        step();
        step();
        n_cmp++;
        if (lights !== lamps(0, 0)) begin
            n_err++;
            $display("FAIL rstyel_timer_green got %b required %b", lights, lamps(0, 0));
        end
        step();
        n_cmp++;
        if (lights !== lamps(0, 1)) begin
            n_err++;
            $display("FAIL rstyel_timer_yellow got %b required %b", lights, lamps(0, 1));
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_rest_in_green();
        test_single_request();
        test_max_out();
        test_round_robin();
        test_reset_mid_yellow();
        step();
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
